adder_timing_ctrl: RTL



---
 rtl/adder_timing_pkg.sv | 17 +
 rtl/ring_edge_sync.sv | 23 ++
 rtl/adder_timing_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/adder_timing_pkg.sv
// Shared types and constants for the instrumented-adder measurement controller.
package adder_timing_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic MODE_RING = 1'b0;
    localparam logic MODE_CAL  = 1'b1;

    localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/ring_edge_sync.sv
// Brings the free-running ring oscillator tap into the system clock domain
// and flags each rising edge as a single-cycle pulse.
module ring_edge_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    input  logic chain_in,
    output logic edge_pulse
);

    // [0],[1] form the synchroniser; [2] is the history bit for edge detect
    logic [2:0] sync_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], chain_in};
        end
    end

    assign edge_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adder_timing_ctrl.sv
// Measurement sequencer: load operands, settle, capture sum, then gate the
// ring oscillator for a programmed window and count its edges.
//
//   state  | meaning
//   IDLE   | waiting for start with active=1
//   SETTLE | operands applied, waiting SETTLE_CYC cycles before sum capture
//   RUN    | ring_en high for the latched window length, edges counted
//   DRAIN  | ring off, edges still in the synchroniser are counted
//   DONE   | one-cycle result strobe; a new start is already accepted here
module adder_timing_ctrl
    import adder_timing_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 32,
    parameter int WINDOW_W   = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                active,
    input  logic                start,
    input  logic                mode,
    input  logic [WIDTH-1:0]    a_in,
    input  logic [WIDTH-1:0]    b_in,
    input  logic [WINDOW_W-1:0] window,
    input  logic [WIDTH-1:0]    sum_in,
    input  logic                chain_in,
    output logic [WIDTH-1:0]    a_out,
    output logic [WIDTH-1:0]    b_out,
    output logic                ring_en,
    output logic                ring_bypass,
    output logic [WIDTH-1:0]    sum_out,
    output logic [CNT_W-1:0]    count_out,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t              state;
    logic [SET_W-1:0]    settle_cnt;
    logic [WINDOW_W-1:0] win_q;
    logic [WINDOW_W-1:0] tmr;
    logic [CNT_W-1:0]    work_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                edge_pulse;
    logic                count_en;
    logic                at_max;

    ring_edge_sync u_sync (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .chain_in   (chain_in),
        .edge_pulse (edge_pulse)
    );

    assign count_en = (state == RUN) || (state == DRAIN);
    assign at_max   = &work_cnt;

    always_comb begin
        cnt_next = work_cnt;
        if (count_en && edge_pulse && !at_max) begin
            cnt_next = work_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            win_q       <= '0;
            tmr         <= '0;
            work_cnt    <= '0;
            a_out       <= '0;
            b_out       <= '0;
            ring_en     <= 1'b0;
            ring_bypass <= 1'b0;
            sum_out     <= '0;
            count_out   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done     <= 1'b0;
            work_cnt <= cnt_next;
            if (count_en && edge_pulse && at_max) begin
                overflow <= 1'b1;
            end

            if (!active) begin
                state   <= IDLE;
                ring_en <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        state <= IDLE;
                        if (start) begin
                            a_out       <= a_in;
                            b_out       <= b_in;
                            ring_bypass <= (mode == MODE_CAL);
                            win_q       <= window;
                            work_cnt    <= '0;
                            overflow    <= 1'b0;
                            settle_cnt  <= SET_W'(SETTLE_CYC - 1);
                            busy        <= 1'b1;
                            state       <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            sum_out <= sum_in;
                            if (win_q != '0) begin
                                ring_en <= 1'b1;
                                tmr     <= win_q - WINDOW_W'(1);
                                state   <= RUN;
                            end else begin
                                tmr   <= WINDOW_W'(DRAIN_CYC - 1);
                                state <= DRAIN;
                            end
                        end else begin
                            settle_cnt <= settle_cnt - SET_W'(1);
                        end
                    end
                    RUN: begin
                        if (tmr == '0) begin
                            ring_en <= 1'b0;
                            tmr     <= WINDOW_W'(DRAIN_CYC - 1);
                            state   <= DRAIN;
                        end else begin
                            tmr <= tmr - WINDOW_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (tmr == '0) begin
                            // include an edge landing on this final drain cycle
                            count_out <= cnt_next;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            tmr <= tmr - WINDOW_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
